// File: rtl/parallel_to_serial.sv
// parallel_to_serial: transmit side of the byte-serial link.
// Takes parallel words over a valid/ready handshake into a one-word holding
// register and shifts each word out one bit per clock, framed by Enable.
// Back-to-back words stream with no idle cycle between frames, and Index
// counts completed words so it tracks the receiver word for word.
module parallel_to_serial #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 8,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   InValid,
  input  logic [DATA_WIDTH-1:0]  InData,
  output logic                   InReady,
  output logic                   Enable,
  output logic                   DataOut,
  output logic                   LastBit,
  output logic [INDEX_WIDTH-1:0] Index
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0]  sh_q, sh_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   enable_q, enable_d;
  logic                   data_out_q, data_out_d;
  logic                   last_bit_q, last_bit_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [CNT_W-1:0]       cnt_inc;

  // Bit that goes on the wire first for a word in transmit order.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
    if (MSB_FIRST) begin
      first_bit = v[DATA_WIDTH-1];
    end else begin
      first_bit = v[0];
    end
  endfunction

  // Move the next bit to be sent into the position first_bit() reads.
  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] v);
    if (MSB_FIRST) begin
      advance = v << 1'b1;
    end else begin
      advance = v >> 1'b1;
    end
  endfunction

  assign cnt_inc = cnt_q + CNT_W'(1'b1);

  // Next-state logic: handshake into HOLD, frame sequencing and word counting.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    enable_d    = enable_q;
    data_out_d  = data_out_q;
    last_bit_d  = last_bit_q;
    index_d     = index_q;

    // A full holding register blocks acceptance, so accept and reload never
    // touch hold_full in the same edge.
    if (InValid && !hold_full_q) begin
      hold_d      = InData;
      hold_full_d = 1'b1;
    end else begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
    end

    case (state_q)
      ST_IDLE: begin
        enable_d   = 1'b0;
        data_out_d = 1'b0;
        last_bit_d = 1'b0;
        if (hold_full_q) begin
          sh_d        = advance(hold_q);
          cnt_d       = '0;
          data_out_d  = first_bit(hold_q);
          enable_d    = 1'b1;
          last_bit_d  = (DATA_WIDTH == 1);
          hold_full_d = 1'b0;
          state_d     = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != LAST_CNT) begin
          cnt_d      = cnt_inc;
          data_out_d = first_bit(sh_q);
          sh_d       = advance(sh_q);
          last_bit_d = (cnt_inc == LAST_CNT);
        end else begin
          // Final bit is on the wire: the word is complete.
          index_d    = index_q + INDEX_WIDTH'(1'b1);
          last_bit_d = 1'b0;
          if (hold_full_q) begin
            // Reload straight away so the next frame follows without a gap.
            sh_d        = advance(hold_q);
            cnt_d       = '0;
            data_out_d  = first_bit(hold_q);
            enable_d    = 1'b1;
            last_bit_d  = (DATA_WIDTH == 1);
            hold_full_d = 1'b0;
            state_d     = ST_SHIFT;
          end else begin
            enable_d   = 1'b0;
            data_out_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        enable_d    = 1'b0;
        data_out_d  = 1'b0;
        last_bit_d  = 1'b0;
        cnt_d       = '0;
        hold_full_d = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any frame in progress and drops the partial word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
      enable_q    <= 1'b0;
      data_out_q  <= 1'b0;
      last_bit_q  <= 1'b0;
      index_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      enable_q    <= enable_d;
      data_out_q  <= data_out_d;
      last_bit_q  <= last_bit_d;
      index_q     <= index_d;
    end
  end

  assign InReady = !hold_full_q;
  assign Enable  = enable_q;
  assign DataOut = data_out_q;
  assign LastBit = last_bit_q;
  assign Index   = index_q;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed testbench for parallel_to_serial: an LSB-first instance covers
// framing, streaming, backpressure, reset abort and Index wrap; an MSB-first
// instance covers bit order.
module tb_parallel_to_serial;

  logic       CLK = 1'b0;
  logic       RST;
  logic       InValid;
  logic [7:0] InData;
  logic       InReady, Enable, DataOut, LastBit;
  logic [7:0] Index;

  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready, m_enable, m_dout, m_last;
  logic [7:0] m_index;

  int checks = 0;
  int errors = 0;

  logic [7:0] lb_words [3] = '{8'h00, 8'hFF, 8'h81};

  parallel_to_serial #(.DATA_WIDTH(8), .INDEX_WIDTH(8), .MSB_FIRST(1'b0)) dut (
    .CLK(CLK), .RST(RST), .InValid(InValid), .InData(InData), .InReady(InReady),
    .Enable(Enable), .DataOut(DataOut), .LastBit(LastBit), .Index(Index)
  );

  parallel_to_serial #(.DATA_WIDTH(8), .INDEX_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .CLK(CLK), .RST(RST), .InValid(m_valid), .InData(m_data), .InReady(m_ready),
    .Enable(m_enable), .DataOut(m_dout), .LastBit(m_last), .Index(m_index)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] seq_val(input int c);
    seq_val = 8'((c * 29 + 7) % 256);
  endfunction

  task automatic do_reset;
    RST = 1'b1; InValid = 1'b0; InData = 8'h00; m_valid = 1'b0; m_data = 8'h00;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RST = 1'b1; InValid = 1'b1; InData = 8'hA5; m_valid = 1'b0; m_data = 8'h00;
    repeat (2) @(negedge CLK);
    checks++;
    if ({Enable, DataOut, LastBit, InReady} !== 4'b0001) begin
      errors++; $display("FAIL reset_flags got %b want %b", {Enable, DataOut, LastBit, InReady}, 4'b0001);
    end
    checks++;
    if (Index !== 8'd0) begin errors++; $display("FAIL reset_index got %0d want 0", Index); end
    InValid = 1'b0;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({Enable, InReady} !== 2'b01) begin
      errors++; $display("FAIL reset_idle got %b want %b", {Enable, InReady}, 2'b01);
    end
  endtask

  task automatic test_single;
    logic [7:0] w;
    do_reset();
    w = 8'hA5;
    InValid = 1'b1; InData = w;
    checks++;
    if (InReady !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", InReady); end
    @(negedge CLK);
    InValid = 1'b0; InData = 8'hFF;
    checks++;
    if ({Enable, InReady} !== 2'b00) begin
      errors++; $display("FAIL single_latency got %b want %b", {Enable, InReady}, 2'b00);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checks++;
      if ({Enable, DataOut, LastBit} !== {1'b1, w[i], (i == 7)} || Index !== 8'd0) begin
        errors++;
        $display("FAIL single_bit%0d got en/do/lb=%b idx=%0d want %b idx=0", i,
                 {Enable, DataOut, LastBit}, Index, {1'b1, w[i], (i == 7)});
      end
    end
    @(negedge CLK);
    checks++;
    if ({Enable, DataOut, LastBit, InReady} !== 4'b0001 || Index !== 8'd1) begin
      errors++; $display("FAIL single_end got %b idx=%0d want 0001 idx=1", {Enable, DataOut, LastBit, InReady}, Index);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (Enable !== 1'b0 || Index !== 8'd1) begin
      errors++; $display("FAIL single_idle got en=%b idx=%0d want en=0 idx=1", Enable, Index);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a, b;
    logic       eb, er;
    logic [7:0] ei;
    do_reset();
    a = 8'h3C; b = 8'hC3;
    InValid = 1'b1; InData = a;
    @(negedge CLK);
    InValid = 1'b0;
    checks++;
    if (InReady !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %b want 0", InReady); end
    for (int j = 0; j < 16; j++) begin
      @(negedge CLK);
      eb = (j < 8) ? a[j] : b[j - 8];
      ei = (j < 8) ? 8'd0 : 8'd1;
      er = (j == 0) || (j >= 8);
      checks++;
      if ({Enable, DataOut, LastBit, InReady} !== {1'b1, eb, (j == 7) || (j == 15), er} || Index !== ei) begin
        errors++;
        $display("FAIL b2b_cycle%0d got en/do/lb/rdy=%b idx=%0d want %b idx=%0d", j,
                 {Enable, DataOut, LastBit, InReady}, Index, {1'b1, eb, (j == 7) || (j == 15), er}, ei);
      end
      if (j == 0) begin
        InValid = 1'b1; InData = b;
      end else begin
        InValid = 1'b0;
      end
    end
    @(negedge CLK);
    checks++;
    if (Enable !== 1'b0 || Index !== 8'd2) begin
      errors++; $display("FAIL b2b_end got en=%b idx=%0d want en=0 idx=2", Enable, Index);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] rx_word;
    int rx_cnt, rx_n, tx_n;
    do_reset();
    rx_word = 8'h00; rx_cnt = 0; rx_n = 0; tx_n = 0;
    for (int cyc = 0; cyc < 100 && rx_n < 3; cyc++) begin
      @(negedge CLK);
      if (Enable) begin
        rx_word[rx_cnt] = DataOut;
        rx_cnt++;
        if (rx_cnt == 8) begin
          checks++;
          if (rx_word !== lb_words[rx_n]) begin
            errors++; $display("FAIL loopback_word%0d got %h want %h", rx_n, rx_word, lb_words[rx_n]);
          end
          rx_n++; rx_cnt = 0;
        end
      end
      if (InReady && tx_n < 3) begin
        InValid = 1'b1; InData = lb_words[tx_n]; tx_n++;
      end else begin
        InValid = 1'b0;
      end
    end
    InValid = 1'b0;
    @(negedge CLK);
    checks++;
    if (rx_n != 3 || Index !== 8'd3) begin
      errors++; $display("FAIL loopback_count got words=%0d idx=%0d want 3 3", rx_n, Index);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] rx_word;
    logic [7:0] exp_w [4];
    int rx_cnt, rx_n;
    do_reset();
    exp_w[0] = seq_val(0); exp_w[1] = seq_val(2); exp_w[2] = seq_val(10); exp_w[3] = seq_val(18);
    rx_word = 8'h00; rx_cnt = 0; rx_n = 0;
    for (int cyc = 0; cyc < 60 && rx_n < 4; cyc++) begin
      @(negedge CLK);
      if (Enable) begin
        rx_word[rx_cnt] = DataOut;
        rx_cnt++;
        if (rx_cnt == 8) begin
          checks++;
          if (rx_word !== exp_w[rx_n]) begin
            errors++; $display("FAIL backpressure_word%0d got %h want %h", rx_n, rx_word, exp_w[rx_n]);
          end
          rx_n++; rx_cnt = 0;
        end
      end
      if (cyc < 20) begin
        InValid = 1'b1; InData = seq_val(cyc);
      end else begin
        InValid = 1'b0;
      end
    end
    InValid = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (rx_n != 4 || Index !== 8'd4 || Enable !== 1'b0) begin
      errors++; $display("FAIL backpressure_count got words=%0d idx=%0d en=%b want 4 4 0", rx_n, Index, Enable);
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] w;
    do_reset();
    InValid = 1'b1; InData = 8'h5A;
    @(negedge CLK);
    InValid = 1'b0;
    repeat (4) @(negedge CLK);
    checks++;
    if ({Enable, DataOut} !== 2'b11) begin
      errors++; $display("FAIL midframe_bit3 got %b want %b", {Enable, DataOut}, 2'b11);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({Enable, DataOut, LastBit, InReady} !== 4'b0001 || Index !== 8'd0) begin
      errors++; $display("FAIL midframe_abort got %b idx=%0d want 0001 idx=0", {Enable, DataOut, LastBit, InReady}, Index);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    w = 8'hC6;
    InValid = 1'b1; InData = w;
    @(negedge CLK);
    InValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checks++;
      if ({Enable, DataOut, LastBit} !== {1'b1, w[i], (i == 7)}) begin
        errors++; $display("FAIL midframe_resend_bit%0d got %b want %b", i, {Enable, DataOut, LastBit}, {1'b1, w[i], (i == 7)});
      end
    end
    @(negedge CLK);
    checks++;
    if (Enable !== 1'b0 || Index !== 8'd1) begin
      errors++; $display("FAIL midframe_index got en=%b idx=%0d want en=0 idx=1", Enable, Index);
    end
  endtask

  task automatic test_msb_order;
    logic [7:0] w;
    do_reset();
    w = 8'h01;
    checks++;
    if (m_ready !== 1'b1) begin errors++; $display("FAIL msb_ready got %b want 1", m_ready); end
    m_valid = 1'b1; m_data = w;
    @(negedge CLK);
    m_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checks++;
      if ({m_enable, m_dout, m_last} !== {1'b1, w[7 - i], (i == 7)}) begin
        errors++; $display("FAIL msb_bit%0d got %b want %b", i, {m_enable, m_dout, m_last}, {1'b1, w[7 - i], (i == 7)});
      end
    end
    @(negedge CLK);
    checks++;
    if (m_enable !== 1'b0 || m_index !== 8'd1) begin
      errors++; $display("FAIL msb_end got en=%b idx=%0d want en=0 idx=1", m_enable, m_index);
    end
  endtask

  task automatic test_wrap;
    int sent, frames;
    do_reset();
    sent = 0; frames = 0;
    for (int cyc = 0; cyc < 2400 && !(frames == 256 && Enable == 1'b0); cyc++) begin
      @(negedge CLK);
      if (Enable && LastBit) begin
        checks++;
        if (Index !== 8'(frames)) begin
          errors++; $display("FAIL wrap_index_frame%0d got %0d want %0d", frames, Index, 8'(frames));
        end
        frames++;
      end
      if (InReady && sent < 256) begin
        InValid = 1'b1; InData = 8'(sent); sent++;
      end else begin
        InValid = 1'b0;
      end
    end
    InValid = 1'b0;
    checks++;
    if (frames != 256 || Index !== 8'd0 || Enable !== 1'b0) begin
      errors++; $display("FAIL wrap_final got frames=%0d idx=%0d en=%b want 256 0 0", frames, Index, Enable);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_loopback();
    test_backpressure();
    test_reset_midframe();
    test_msb_order();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
